// File: rtl/ps2_mouse_init.sv
// rtl/ps2_mouse_init.sv - PS/2 mouse bring-up command sequencer with bounded retries
// Optional wheel (IntelliMouse) detection is built when MOUSE_WHEEL_EN is defined.
module ps2_mouse_init #(
    parameter int         TIMEOUT_CYC = 50_000_000,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       tx_err,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       run,
    output logic       busy,
    output logic       error,
    output logic [2:0] err_code,
    output logic       wheel
);
`ifdef MOUSE_WHEEL_EN
    localparam logic [3:0] LAST_STEP = 4'd10;
    localparam logic [3:0] ID_STEP   = 4'd7;
`else
    localparam logic [3:0] LAST_STEP = 4'd3;
`endif
    localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRY);
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_BAT, WAIT_ID, RUN, FAIL} state_t;

    state_t      state, state_d;
    logic [3:0]  step, step_d;
    logic [1:0]  retry, retry_d;
    logic [31:0] timer, timer_d;
    logic        bat_aa, bat_aa_d;
    logic [2:0]  code_d;
    logic        fail;
    logic [2:0]  fail_code;
`ifdef MOUSE_WHEEL_EN
    logic        wheel_q, wheel_d;
`endif

    function automatic logic [7:0] cmd_byte(input logic [3:0] s);
`ifdef MOUSE_WHEEL_EN
        case (s)
            4'd0:    cmd_byte = 8'hFF;
            4'd2:    cmd_byte = 8'hC8;
            4'd4:    cmd_byte = 8'h64;
            4'd6:    cmd_byte = 8'h50;
            4'd7:    cmd_byte = 8'hF2;
            4'd9:    cmd_byte = SAMPLE_RATE;
            4'd10:   cmd_byte = 8'hF4;
            default: cmd_byte = 8'hF3;
        endcase
`else
        case (s)
            4'd0:    cmd_byte = 8'hFF;
            4'd1:    cmd_byte = 8'hF3;
            4'd2:    cmd_byte = SAMPLE_RATE;
            default: cmd_byte = 8'hF4;
        endcase
`endif
    endfunction

    always_comb begin
        state_d   = state;
        step_d    = step;
        retry_d   = retry;
        timer_d   = timer;
        bat_aa_d  = bat_aa;
        code_d    = err_code;
`ifdef MOUSE_WHEEL_EN
        wheel_d   = wheel_q;
`endif
        fail      = 1'b0;
        fail_code = 3'd0;
        // start passes through IDLE so tx_valid visibly drops for a cycle
        if (start) begin
            state_d  = IDLE;
            step_d   = 4'd0;
            retry_d  = 2'd0;
            timer_d  = '0;
            bat_aa_d = 1'b0;
            code_d   = 3'd0;
`ifdef MOUSE_WHEEL_EN
            wheel_d  = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state_d = SEND;
                    step_d  = 4'd0;
                end
                SEND: begin
                    if (tx_ready) begin
                        state_d = WAIT_ACK;
                        timer_d = '0;
                    end
                end
                WAIT_ACK, WAIT_BAT, WAIT_ID: begin
                    timer_d = timer + 32'd1;
                    if (tx_err) begin
                        fail      = 1'b1;
                        fail_code = 3'd4;
                    end else if (rx_valid) begin
                        timer_d = '0;
                        if (state == WAIT_ACK) begin
                            if (rx_data == 8'hFA) begin
                                if (step == 4'd0) begin
                                    state_d  = WAIT_BAT;
                                    bat_aa_d = 1'b0;
                                end else if (step == LAST_STEP) begin
                                    state_d = RUN;
`ifdef MOUSE_WHEEL_EN
                                end else if (step == ID_STEP) begin
                                    state_d = WAIT_ID;
`endif
                                end else begin
                                    step_d  = step + 4'd1;
                                    state_d = SEND;
                                end
                            end else if (rx_data == 8'hFE && retry != RETRY_MAX) begin
                                retry_d = retry + 2'd1;
                                state_d = SEND;
                            end else begin
                                fail      = 1'b1;
                                fail_code = 3'd3;
                            end
                        end else if (state == WAIT_BAT) begin
                            if (rx_data == 8'hFC) begin
                                fail      = 1'b1;
                                fail_code = 3'd2;
                            end else if (!bat_aa && rx_data == 8'hAA) begin
                                bat_aa_d = 1'b1;
                            end else if (bat_aa && rx_data == 8'h00) begin
                                step_d  = 4'd1;
                                state_d = SEND;
                            end else begin
                                fail      = 1'b1;
                                fail_code = 3'd3;
                            end
                        end else begin
                            // any device ID is acceptable; only 03 means a wheel
`ifdef MOUSE_WHEEL_EN
                            wheel_d = (rx_data == 8'h03);
`endif
                            step_d  = step + 4'd1;
                            state_d = SEND;
                        end
                    end else if (timer == TIMER_LAST) begin
                        fail      = 1'b1;
                        fail_code = 3'd1;
                    end
                end
                default: ;
            endcase
            if (fail) begin
                code_d  = fail_code;
                timer_d = '0;
                if (retry == RETRY_MAX) begin
                    state_d = FAIL;
                end else begin
                    retry_d = retry + 2'd1;
                    step_d  = 4'd0;
                    state_d = SEND;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= 4'd0;
            retry    <= 2'd0;
            timer    <= '0;
            bat_aa   <= 1'b0;
            err_code <= 3'd0;
`ifdef MOUSE_WHEEL_EN
            wheel_q  <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            step     <= step_d;
            retry    <= retry_d;
            timer    <= timer_d;
            bat_aa   <= bat_aa_d;
            err_code <= code_d;
`ifdef MOUSE_WHEEL_EN
            wheel_q  <= wheel_d;
`endif
        end
    end

    assign tx_valid = (state == SEND);
    assign tx_data  = tx_valid ? cmd_byte(step) : 8'h00;
    assign run      = (state == RUN);
    assign error    = (state == FAIL);
    assign busy     = !(state == IDLE || state == RUN || state == FAIL);
`ifdef MOUSE_WHEEL_EN
    assign wheel    = wheel_q;
`else
    assign wheel    = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_mouse_init.sv
// tb/tb_ps2_mouse_init.sv - randomized bench for ps2_mouse_init with a response-queue reference model
`timescale 1ns/1ps
module tb_ps2_mouse_init;
    localparam int T    = 100;
    localparam int MAXR = 3;
    localparam int ANY  = 256;
`ifdef MOUSE_WHEEL_EN
    localparam int NSTEP = 11;
`else
    localparam int NSTEP = 4;
`endif
    localparam int M_COOP = 0, M_FE = 1, M_FC = 2, M_TO = 3, M_STALL = 4, M_RAND = 5;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       tx_ready = 1'b0, tx_err = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid, run, busy, error, wheel;
    logic [2:0] err_code;

    ps2_mouse_init #(.TIMEOUT_CYC(T), .MAX_RETRY(MAXR), .SAMPLE_RATE(8'd100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_err(tx_err), .rx_data(rx_data), .rx_valid(rx_valid),
        .run(run), .busy(busy), .error(error), .err_code(err_code), .wheel(wheel));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] cmd_tbl [NSTEP];
    logic [7:0] seq[$];

    // Reference model: the device's outstanding replies are a queue of expected bytes
    bit m_idle = 1, m_sending = 0, m_run = 0, m_err = 0, m_wheel = 0;
    int m_step = 0, m_retry = 0, m_code = 0, m_tick = 0;
    int exp_q[$];

    function automatic void m_reset();
        m_idle = 1; m_sending = 0; m_run = 0; m_err = 0; m_wheel = 0;
        m_step = 0; m_retry = 0; m_code = 0; m_tick = 0;
        exp_q.delete();
    endfunction

    function automatic void m_fail(int c);
        m_code = c;
        exp_q.delete();
        if (m_retry == MAXR) begin
            m_err = 1; m_sending = 0;
        end else begin
            m_retry++; m_step = 0; m_sending = 1;
        end
    endfunction

    function automatic void m_accept(logic [7:0] b);
        int f = exp_q[0];
        if (f == ANY || int'(b) == f) begin
            if (f == ANY) m_wheel = (b == 8'h03);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                if (m_step == NSTEP - 1) m_run = 1;
                else begin m_step++; m_sending = 1; end
            end
        end else if (b == 8'hFC && (f == 'hAA || f == 'h00)) m_fail(2);
        else if (b == 8'hFE && f == 'hFA && m_retry < MAXR) begin
            m_retry++; m_sending = 1; exp_q.delete();
        end else m_fail(3);
    endfunction

    function automatic void m_step_cycle();
        if (!rst_n) m_reset();
        else if (start) begin m_reset(); end
        else if (m_idle) begin m_idle = 0; m_sending = 1; m_step = 0; end
        else if (m_run || m_err) begin end
        else if (m_sending) begin
            if (tx_ready) begin
                m_sending = 0; m_tick = 0;
                exp_q.delete();
                exp_q.push_back('hFA);
                if (m_step == 0) begin exp_q.push_back('hAA); exp_q.push_back('h00); end
                if (cmd_tbl[m_step] == 8'hF2) exp_q.push_back(ANY);
            end
        end
        else if (tx_err) m_fail(4);
        else if (rx_valid) begin m_tick = 0; m_accept(rx_data); end
        else if (m_tick == T - 1) m_fail(1);
        else m_tick++;
    endfunction

    always @(posedge clk) begin
        m_step_cycle();
        #1;
        chk("tx_valid", tx_valid, m_sending);
        if (m_sending) chk("tx_data", tx_data, cmd_tbl[m_step]);
        chk("run", run, m_run);
        chk("busy", busy, !(m_idle || m_run || m_err));
        chk("error", error, m_err);
        chk("err_code", err_code, m_code);
        chk("wheel", wheel, m_wheel);
    end

    // Device/transceiver stimulus
    typedef struct packed {logic is_err; logic [7:0] b;} resp_t;
    resp_t      resp_q[$];
    int         gap = 0, mode = M_COOP;
    bit         fe_done = 0, to_done = 0, hold_ready = 0;
    logic [7:0] wheel_id = 8'h03;
    logic [7:0] tx_log[$];

    function automatic void push_resp(logic e, logic [7:0] b);
        resp_t r;
        r.is_err = e; r.b = b;
        if (resp_q.size() == 0) gap = $urandom_range(1, 4);
        resp_q.push_back(r);
    endfunction

    function automatic void respond(logic [7:0] c);
        int r = 100;
        if (mode == M_RAND) r = $urandom_range(0, 99);
        if (r < 4) push_resp(0, 8'hFE);
        else if (r < 8) push_resp(0, 8'($urandom_range(0, 255)));
        else if (r < 11) begin end
        else if (r < 14) push_resp(1, 8'h00);
        else if (c == 8'hFF) begin
            if (mode == M_FC || r < 18) begin push_resp(0, 8'hFA); push_resp(0, 8'hFC); end
            else if (mode == M_STALL) push_resp(0, 8'hFA);
            else begin push_resp(0, 8'hFA); push_resp(0, 8'hAA); push_resp(0, 8'h00); end
        end
        else if (c == 8'hF2) begin push_resp(0, 8'hFA); push_resp(0, wheel_id); end
        else if (c == 8'hF3 && mode == M_FE && !fe_done) begin fe_done = 1; push_resp(0, 8'hFE); end
        else if (c == 8'hF4 && mode == M_TO && !to_done) to_done = 1;
        else push_resp(0, 8'hFA);
    endfunction

    task automatic cycle();
        @(negedge clk);
        rx_valid = 0; tx_err = 0; start = 0;
        if (resp_q.size() > 0) begin
            if (gap > 0) gap--;
            else begin
                resp_t r = resp_q.pop_front();
                if (r.is_err) tx_err = 1;
                else begin rx_valid = 1; rx_data = r.b; end
                gap = $urandom_range(0, 3);
            end
        end
        tx_ready = !hold_ready && ($urandom_range(0, 2) != 0);
        if (tx_valid && tx_ready) begin
            tx_log.push_back(tx_data);
            respond(tx_data);
        end
    endtask

    task automatic restart(int md);
        mode = md; fe_done = 0; to_done = 0;
        resp_q.delete(); tx_log.delete();
        @(negedge clk);
        rx_valid = 0; tx_err = 0; tx_ready = 0; start = 1;
        cycle();
    endtask

    task automatic run_done(string name, int bound);
        int n = 0;
        while (!(run || error) && n < bound) begin cycle(); n++; end
        chk({name, " finished within budget"}, run || error, 1);
    endtask

    task automatic chk_log(string name, logic [7:0] expq[$]);
        chk({name, " tx count"}, tx_log.size(), expq.size());
        for (int i = 0; i < expq.size() && i < tx_log.size(); i++)
            chk($sformatf("%s tx[%0d]", name, i), tx_log[i], expq[i]);
    endtask

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
`ifdef MOUSE_WHEEL_EN
        cmd_tbl = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF3, 8'h64, 8'hF4};
`else
        cmd_tbl = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
`endif
        for (int i = 0; i < NSTEP; i++) seq.push_back(cmd_tbl[i]);

        repeat (3) @(negedge clk);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 8'h00);
        chk("reset busy", busy, 0);
        chk("reset err_code", err_code, 0);
        rst_n = 1;

        // clean init via the implicit start
        mode = M_COOP; wheel_id = 8'h03;
        run_done("clean", 3000);
        chk_log("clean", seq);
        chk("clean run", run, 1);
        chk("clean busy", busy, 0);
        chk("clean error", error, 0);
        chk("clean err_code", err_code, 0);
`ifdef MOUSE_WHEEL_EN
        chk("clean wheel", wheel, 1);
        wheel_id = 8'h00;
        restart(M_COOP);
        run_done("no wheel", 3000);
        chk("no wheel run", run, 1);
        chk("no wheel wheel", wheel, 0);
        wheel_id = 8'h03;
`else
        chk("clean wheel", wheel, 0);
`endif

        // FE on first F3 causes a single retransmission
        restart(M_FE);
        run_done("resend", 3000);
        q = seq; q.insert(1, 8'hF3);
        chk_log("resend", q);
        chk("resend run", run, 1);
        chk("resend err_code", err_code, 0);

        // BAT failure every time: four FF attempts then FAIL
        restart(M_FC);
        run_done("bat fail", 3000);
        q.delete(); repeat (4) q.push_back(8'hFF);
        chk_log("bat fail", q);
        chk("bat fail error", error, 1);
        chk("bat fail err_code", err_code, 2);
        chk("bat fail run", run, 0);
        chk("bat fail busy", busy, 0);

        // silent F4 once: timeout, then a full clean pass
        restart(M_TO);
        run_done("timeout", 3000);
        q = seq; for (int i = 0; i < NSTEP; i++) q.push_back(seq[i]);
        chk_log("timeout", q);
        chk("timeout run", run, 1);
        chk("timeout err_code", err_code, 1);

        // start mid-SEND with the transceiver stalled
        hold_ready = 1;
        restart(M_COOP);
        repeat (3) cycle();
        chk("stall tx_valid", tx_valid, 1);
        chk("stall tx_data", tx_data, 8'hFF);
        @(negedge clk); start = 1;
        cycle();
        chk("start drops tx_valid", tx_valid, 0);
        cycle();
        chk("start reissue tx_valid", tx_valid, 1);
        chk("start reissue tx_data", tx_data, 8'hFF);
        hold_ready = 0;

        // async reset while waiting for the BAT result
        restart(M_STALL);
        begin
            int n = 0;
            while (!(tx_log.size() >= 1 && resp_q.size() == 0) && n < 200) begin cycle(); n++; end
            chk("stall reached WAIT_BAT", tx_log.size() >= 1 && resp_q.size() == 0, 1);
        end
        repeat (3) cycle();
        chk("pre-reset busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("async reset tx_valid", tx_valid, 0);
        chk("async reset busy", busy, 0);
        chk("async reset run", run, 0);
        chk("async reset error", error, 0);
        chk("async reset err_code", err_code, 0);
        chk("async reset wheel", wheel, 0);
        repeat (2) @(negedge clk);
        mode = M_COOP; resp_q.delete(); tx_log.delete();
        rst_n = 1;
        run_done("after reset", 3000);
        chk_log("after reset", seq);

        // randomized device behaviour, occasional mid-sequence restarts
        for (int it = 0; it < 24; it++) begin
            wheel_id = $urandom_range(0, 1) ? 8'h03 : 8'($urandom_range(0, 255));
            restart(M_RAND);
            if (it % 5 == 4) begin
                repeat ($urandom_range(0, 40)) cycle();
                restart(M_RAND);
            end
            run_done($sformatf("random %0d", it), 6000);
            repeat ($urandom_range(2, 8)) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
